// File: rtl/vc_traffic_requester.sv
// vc_traffic_requester: LFSR-driven per-input VC request source feeding the output arbiter under test.
module vc_traffic_requester #(
  parameter int VC_NUM = 3,
  parameter int PRIO_NUM = 2,
  parameter int INPUT_NUM = 4,
  parameter int MAX_PKTS = 4,
  parameter int HOLD_MAX = 3,
  parameter int LFSR_W = 16,
  localparam int VCS = VC_NUM * PRIO_NUM,
  localparam int VCW = (VCS > 1) ? $clog2(VCS) : 1,
  localparam int SELW = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     seed_load,
  input  logic [LFSR_W-1:0]        seed,
  input  logic [7:0]               drop_thresh,
  input  logic                     mode_fixed,
  input  logic [INPUT_NUM*VCW-1:0] fixed_vc,
  input  logic                     cts,
  input  logic [SELW-1:0]          selected_input,
  input  logic                     last,
  output logic [INPUT_NUM*VCS-1:0] o_request,
  output logic [INPUT_NUM-1:0]     o_busy,
  output logic [31:0]              o_total_pkts
);
  localparam int RW = $clog2(MAX_PKTS + 1);
  localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int CW = $clog2(INPUT_NUM + 1);
  typedef enum logic [1:0] {IDLE, REQ, GRANTED, HOLD} state_t;
  logic [LFSR_W-1:0]    base_seed;
  logic [INPUT_NUM-1:0] done;
  logic [CW-1:0]        done_cnt;
  // reset reuses the seed-load path with the fixed power-on seed
  assign base_seed = resetn ? seed : LFSR_W'(16'hACE1);
  for (genvar i = 0; i < INPUT_NUM; i++) begin : g_in
    state_t            st, st_n;
    logic [LFSR_W-1:0] lfsr, rot;
    logic [VCW-1:0]    vc, vc_n;
    logic [RW-1:0]     rem, rem_n;
    logic [HW-1:0]     hold, hold_n;
    logic              sel, drop, beat, fin;
    assign rot = (base_seed << i) | (base_seed >> (LFSR_W - i));
    assign sel = 32'(selected_input) == i;
    assign drop = !mode_fixed && lfsr[15:8] < drop_thresh;
    assign beat = last && sel;
    assign fin = st == GRANTED && beat && rem == RW'(1);
    assign done[i] = st == GRANTED && beat;
    assign o_busy[i] = st != IDLE;
    // the final beat releases the request in the same cycle
    assign o_request[i*VCS +: VCS] = ((st == REQ && !drop) || (st == GRANTED && !fin)) ? VCS'(1) << vc : '0;
    always_ff @(posedge clk)
      if (!resetn || seed_load) lfsr <= (rot == '0) ? LFSR_W'(1) : rot;
      else lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_W'(16'hB400) : '0);
    always_ff @(posedge clk)
      if (!resetn) begin
        st <= IDLE;
        vc <= '0;
        rem <= '0;
        hold <= '0;
      end else begin
        st <= st_n;
        vc <= vc_n;
        rem <= rem_n;
        hold <= hold_n;
      end
    always_comb begin
      st_n = st;
      vc_n = vc;
      rem_n = rem;
      hold_n = hold;
      case (st)
        IDLE: if (enable && lfsr[0]) begin
          st_n = REQ;
          vc_n = VCW'((mode_fixed ? 32'(fixed_vc[i*VCW +: VCW]) : 32'(lfsr[VCW+1:2])) % VCS);
          rem_n = mode_fixed ? RW'(MAX_PKTS) : RW'(32'(lfsr[7:4]) % MAX_PKTS + 1);
        end
        REQ: st_n = (sel && cts) ? GRANTED : enable ? REQ : IDLE;
        GRANTED: if (beat) begin
          rem_n = rem - RW'(1);
          st_n = fin ? HOLD : GRANTED;
          hold_n = fin ? HW'(32'(lfsr[11:10]) % (HOLD_MAX + 1)) : hold;
        end
        default: begin
          st_n = (hold == '0) ? IDLE : HOLD;
          hold_n = (hold == '0) ? hold : hold - HW'(1);
        end
      endcase
    end
  end
  always_comb begin
    done_cnt = '0;
    for (int k = 0; k < INPUT_NUM; k++) done_cnt = done_cnt + CW'(done[k]);
  end
  always_ff @(posedge clk)
    if (!resetn) o_total_pkts <= '0;
    else o_total_pkts <= o_total_pkts + 32'(done_cnt);
endmodule

// File: tb/tb_vc_traffic_requester.sv
// tb_vc_traffic_requester: directed stimulus against a per-cycle reference model of the requester.
module tb_vc_traffic_requester;
  localparam int N = 4, V = 6, MP = 4, HM = 3;
  localparam int P_IDLE = 0, P_REQ = 1, P_GNT = 2, P_HOLD = 3;
  logic clk = 0, resetn = 0, enable = 0, seed_load = 0, mode_fixed = 0, cts = 0, last = 0;
  logic [15:0] seed = '0;
  logic [7:0] drop_thresh = '0;
  logic [11:0] fixed_vc = '0;
  logic [1:0] selected_input = '0;
  logic [23:0] o_request;
  logic [3:0] o_busy;
  logic [31:0] o_total_pkts;
  int checks = 0, errors = 0;
  int ph [N], mvc [N], left [N], idle_wait [N];
  logic [15:0] ml [N];
  int mtotal = 0;
  bit mvalid = 0;
  logic [23:0] tr [2][64];

  always #5 clk = ~clk;

  vc_traffic_requester dut (
    .clk(clk), .resetn(resetn), .enable(enable), .seed_load(seed_load), .seed(seed),
    .drop_thresh(drop_thresh), .mode_fixed(mode_fixed), .fixed_vc(fixed_vc), .cts(cts),
    .selected_input(selected_input), .last(last), .o_request(o_request), .o_busy(o_busy),
    .o_total_pkts(o_total_pkts)
  );

  function automatic logic [15:0] lstep(logic [15:0] x);
    return (x / 16'd2) ^ ((x % 16'd2 == 16'd1) ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] rot_seed(logic [15:0] s, int i);
    logic [31:0] d;
    d = {s, s} << i;
    return (d[31:16] == 16'h0) ? 16'h0001 : d[31:16];
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // compare DUT against the model for this cycle, then advance the model across the coming edge
  task automatic model();
    logic [23:0] er;
    logic [3:0] eb;
    logic [15:0] l;
    bit drop, mine;
    if (mvalid) begin
      er = '0;
      eb = '0;
      for (int i = 0; i < N; i++) begin
        drop = !mode_fixed && ml[i][15:8] < drop_thresh;
        mine = selected_input == 2'(i);
        if ((ph[i] == P_REQ && !drop) || (ph[i] == P_GNT && !(last && mine && left[i] == 1)))
          er[i*V + mvc[i]] = 1'b1;
        eb[i] = ph[i] != P_IDLE;
      end
      chk("model_request", 32'(o_request), 32'(er));
      chk("model_busy", 32'(o_busy), 32'(eb));
      chk("model_total", o_total_pkts, mtotal);
    end
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin
        ph[i] = P_IDLE; mvc[i] = 0; left[i] = 0; idle_wait[i] = 0;
        ml[i] = rot_seed(16'hACE1, i);
      end
      mtotal = 0;
      mvalid = 1;
    end else begin
      for (int i = 0; i < N; i++) begin
        l = ml[i];
        mine = selected_input == 2'(i);
        case (ph[i])
          P_IDLE: if (enable && l[0]) begin
            ph[i] = P_REQ;
            mvc[i] = mode_fixed ? int'(fixed_vc[i*3 +: 3]) % V : int'(l[4:2]) % V;
            left[i] = mode_fixed ? MP : int'(l[7:4]) % MP + 1;
          end
          P_REQ: if (cts && mine) ph[i] = P_GNT; else if (!enable) ph[i] = P_IDLE;
          P_GNT: if (last && mine) begin
            mtotal++;
            if (left[i] == 1) begin
              ph[i] = P_HOLD;
              idle_wait[i] = int'(l[11:10]) % (HM + 1);
            end else left[i]--;
          end
          default: if (idle_wait[i] == 0) ph[i] = P_IDLE; else idle_wait[i]--;
        endcase
        ml[i] = seed_load ? rot_seed(seed, i) : lstep(l);
      end
    end
  endtask

  task automatic clk1();
    @(negedge clk);
    model();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input int i);
    int n = 0;
    while (!o_busy[i] && n < 64) begin clk1(); n++; end
    chk("wait_busy", 32'(o_busy[i]), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    enable = 0; cts = 0; last = 1;
    while (o_busy != 0 && n < 40) begin
      selected_input = 2'(n % 4);
      clk1();
      n++;
    end
    last = 0;
    chk("drain", 32'(o_busy), 0);
  endtask

  task automatic count_drops(output int reqc, output int drops);
    int n = 0;
    reqc = 0;
    drops = 0;
    while (reqc < 10000 && n < 5000) begin
      for (int i = 0; i < N; i++)
        if (o_busy[i]) begin
          reqc++;
          if (o_request[i*V +: V] == '0) drops++;
        end
      clk1();
      n++;
    end
    chk("req_cycles", 32'(reqc >= 10000), 1);
  endtask

  task automatic run_trace(input logic [15:0] s, input int w);
    seed = s; seed_load = 1; enable = 0;
    clk1();
    seed_load = 0; mode_fixed = 0; drop_thresh = 8'd64; enable = 1;
    for (int k = 0; k < 64; k++) begin
      cts = (k % 5 == 2);
      selected_input = 2'(k % 4);
      last = (k % 3 == 0);
      #1 tr[w][k] = o_request;
      clk1();
    end
    cts = 0; last = 0;
    wait_idle();
  endtask

  initial begin
    int reqc, drops, found, n, diff, act;
    chk("pin_rot1", 32'(rot_seed(16'hACE1, 1)), 32'h59C3);
    chk("pin_rot2", 32'(rot_seed(16'hACE1, 2)), 32'hB386);
    chk("pin_step", 32'(lstep(16'hACE1)), 32'hE270);
    chk("pin_step_even", 32'(lstep(16'h0002)), 32'h0001);
    chk("pin_zero_seed", 32'(rot_seed(16'h0000, 3)), 32'h0001);
    repeat (2) clk1();
    resetn = 1;
    for (int k = 0; k < 20; k++) begin
      clk1();
      chk("reset_req", 32'(o_request), 0);
      chk("reset_busy", 32'(o_busy), 0);
      chk("reset_total", o_total_pkts, 0);
    end
    // fixed mode, input0 on VC5, four packets
    mode_fixed = 1; fixed_vc = {3'd0, 3'd7, 3'd2, 3'd5}; enable = 1;
    wait_busy(0);
    chk("fixed_vc5_req", 32'(o_request[5:0]), 32'b100000);
    cts = 1; selected_input = 0; enable = 0;
    clk1();
    cts = 0;
    chk("granted_busy", 32'(o_busy[0]), 1);
    for (int k = 1; k <= 4; k++) begin
      last = 1;
      #1 chk("req_at_last", 32'(o_request[5]), 32'(k < 4));
      clk1();
    end
    last = 0;
    chk("total_after_4", o_total_pkts, 4);
    n = 0;
    while (o_busy[0] && n < 4) begin clk1(); n++; end
    chk("hold_to_idle", 32'(o_busy[0]), 0);
    // last for another input leaves input1 untouched
    wait_idle();
    enable = 1;
    wait_busy(1);
    cts = 1; selected_input = 1; enable = 0;
    clk1();
    cts = 0; last = 1; selected_input = 2;
    #1 chk("other_last_req", 32'(o_request[11:6]), 32'b000100);
    clk1();
    last = 0;
    chk("other_last_held", 32'(o_request[11:6]), 32'b000100);
    chk("other_last_total", o_total_pkts, 4);
    wait_idle();
    chk("input1_total", o_total_pkts, 8);
    // withdraw vs grant race on input2 (fixed_vc 7 reduces to 1)
    enable = 1;
    wait_busy(2);
    enable = 0;
    clk1();
    chk("withdraw_busy", 32'(o_busy[2]), 0);
    chk("withdraw_req", 32'(o_request[17:12]), 0);
    enable = 1;
    wait_busy(2);
    enable = 0; cts = 1; selected_input = 2;
    clk1();
    cts = 0;
    chk("race_busy", 32'(o_busy[2]), 1);
    chk("race_req", 32'(o_request[17:12]), 32'b000010);
    wait_idle();
    chk("input2_total", o_total_pkts, 12);
    // drop statistics
    mode_fixed = 0; drop_thresh = 8'd0; enable = 1;
    count_drops(reqc, drops);
    chk("no_drops", drops, 0);
    drop_thresh = 8'd128;
    count_drops(reqc, drops);
    chk("drop_rate", 32'(drops * 100 >= 45 * reqc && drops * 100 <= 55 * reqc), 1);
    found = -1; n = 0;
    while (found < 0 && n < 200) begin
      for (int i = N - 1; i >= 0; i--)
        if (o_busy[i] && o_request[i*V +: V] == '0) found = i;
      if (found < 0) begin clk1(); n++; end
    end
    chk("drop_seen", 32'(found >= 0), 1);
    if (found >= 0) begin
      cts = 1; selected_input = 2'(found);
      clk1();
      cts = 0;
      chk("drop_grant_busy", 32'(o_busy[found]), 1);
      chk("drop_grant_req", 32'(o_request[found*V +: V] != '0), 1);
    end
    wait_idle();
    // reproducibility from seed
    run_trace(16'h1234, 0);
    run_trace(16'h1234, 1);
    diff = 0; act = 0;
    for (int k = 0; k < 64; k++) begin
      if (tr[0][k] !== tr[1][k]) diff++;
      if (tr[0][k] != '0) act++;
    end
    chk("trace_repeat", diff, 0);
    chk("trace_active", 32'(act > 0), 1);
    seed = 16'h0000; seed_load = 1;
    clk1();
    seed_load = 0;
    chk("seed0_model", 32'(ml[0]), 1);
    enable = 1;
    clk1();
    chk("seed0_all_req", 32'(o_busy), 32'hF);
    wait_idle();
    // reset in the middle of a grant
    mode_fixed = 1; enable = 1;
    wait_busy(3);
    cts = 1; selected_input = 3; enable = 0;
    clk1();
    cts = 0;
    chk("pre_reset_busy", 32'(o_busy[3]), 1);
    resetn = 0;
    clk1();
    chk("midreset_busy", 32'(o_busy), 0);
    chk("midreset_req", 32'(o_request), 0);
    chk("midreset_total", o_total_pkts, 0);
    resetn = 1;
    clk1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
